// File: rtl/pipelined_mantissa_multiplier_pkg.sv
// Shared constants and helpers for the pipelined Booth mantissa multiplier.
package pipelined_mantissa_multiplier_pkg;

    // Widest mask ever needed: OUT_W <= 2*MANT_W <= 48.
    localparam int unsigned MASK_MAX_W = 48;

    // Radix-4 Booth digit; the MSB marks a negated multiple.
    typedef enum logic [2:0] {
        BoothZero = 3'd0,
        BoothPos1 = 3'd1,
        BoothPos2 = 3'd2,
        BoothNeg1 = 3'd5,
        BoothNeg2 = 3'd6
    } booth_dig_e;

    function automatic int unsigned booth_rows(input int unsigned mant_w);
        return mant_w / 2 + 1;
    endfunction

    // Number of low product bits dropped to fit the retained width.
    function automatic int unsigned prod_shift(input int unsigned mant_w,
                                               input int unsigned out_w);
        return 2 * mant_w - out_w;
    endfunction

    // All-ones shifted left by 2*prec, cleared above out_w.
    function automatic logic [MASK_MAX_W-1:0] prec_mask(input logic [1:0]  prec,
                                                        input int unsigned out_w);
        logic [MASK_MAX_W-1:0] m;
        m = {MASK_MAX_W{1'b1}} << {prec, 1'b0};
        for (int unsigned i = 0; i < MASK_MAX_W; i++) begin
            if (i >= out_w) m[i] = 1'b0;
        end
        return m;
    endfunction

    // Bits are {b[2i+1], b[2i], b[2i-1]}.
    function automatic booth_dig_e booth_encode(input logic [2:0] bits);
        booth_dig_e d;
        unique case (bits)
            3'b001, 3'b010: d = BoothPos1;
            3'b011:         d = BoothPos2;
            3'b100:         d = BoothNeg2;
            3'b101, 3'b110: d = BoothNeg1;
            default:        d = BoothZero;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_row_gen.sv
// One Booth partial-product row: digit select, weight by 4^ROW, floor shift, precision mask.
module booth_row_gen
    import pipelined_mantissa_multiplier_pkg::*;
#(
    parameter int unsigned MANT_W = 8,
    parameter int unsigned OUT_W  = 11,
    parameter int unsigned ROW    = 0
) (
    input  logic [MANT_W-1:0] i_a,
    input  logic [2:0]        i_bits,
    input  logic [1:0]        i_prec,
    output logic [OUT_W-1:0]  o_row
);
    localparam int unsigned SHIFT  = prod_shift(MANT_W, OUT_W);
    // 2*a*4^(ROW max) needs 2*MANT_W+1 magnitude bits plus sign; one bit of margin.
    localparam int unsigned FULL_W = 2 * MANT_W + 3;

    booth_dig_e               w_dig;
    logic [FULL_W-1:0]        w_mag;
    logic [FULL_W-1:0]        w_val;
    logic signed [FULL_W-1:0] w_shifted;

    // Build the signed row value, then drop SHIFT bits with floor rounding.
    always_comb begin
        w_dig = booth_encode(i_bits);
        w_mag = FULL_W'(i_a);
        if (w_dig == BoothPos2 || w_dig == BoothNeg2) w_mag = w_mag << 1;
        if (w_dig == BoothZero) w_mag = '0;
        w_mag     = w_mag << (2 * ROW);
        w_val     = (w_dig == BoothNeg1 || w_dig == BoothNeg2) ? -w_mag : w_mag;
        w_shifted = $signed(w_val) >>> SHIFT;
        o_row     = OUT_W'(w_shifted) & OUT_W'(prec_mask(i_prec, OUT_W));
    end

endmodule

// File: rtl/pipelined_mantissa_multiplier.sv
// Three-stage approximate Booth multiplier: S1 rows+mask, S2 carry-save, S3 final add.
module pipelined_mantissa_multiplier
    import pipelined_mantissa_multiplier_pkg::*;
#(
    parameter int unsigned MANT_W = 8,
    parameter int unsigned OUT_W  = MANT_W + 3,
    parameter int unsigned TAG_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [MANT_W-1:0] i_in_a,
    input  logic [MANT_W-1:0] i_in_b,
    input  logic [1:0]        i_in_prec,
    input  logic [TAG_W-1:0]  i_in_tag,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [OUT_W-1:0]  o_out_prod,
    output logic [TAG_W-1:0]  o_out_tag
);
    localparam int unsigned ROWS = booth_rows(MANT_W);

    // b with b[-1] = 0 at the bottom and zero padding above the MSB.
    logic [MANT_W+2:0] w_b_ext;
    logic [OUT_W-1:0]  w_rows [ROWS];
    logic [OUT_W-1:0]  w_csa_sum, w_csa_carry, w_csa_tmp;
    logic              w_s1_en, w_s2_en, w_s3_en;

    logic              r_s1_valid, r_s2_valid, r_s3_valid;
    logic [OUT_W-1:0]  r_s1_rows [ROWS];
    logic [TAG_W-1:0]  r_s1_tag, r_s2_tag, r_s3_tag;
    logic [OUT_W-1:0]  r_s2_sum, r_s2_carry, r_s3_prod;

    assign w_b_ext = {2'b00, i_in_b, 1'b0};

    for (genvar g = 0; g < ROWS; g++) begin : g_row
        booth_row_gen #(
            .MANT_W (MANT_W),
            .OUT_W  (OUT_W),
            .ROW    (g)
        ) u_row (
            .i_a    (i_in_a),
            .i_bits (w_b_ext[2*g+2 -: 3]),
            .i_prec (i_in_prec),
            .o_row  (w_rows[g])
        );
    end

    // A stage may load when it is empty or its content moves on this cycle.
    always_comb begin
        w_s3_en    = !r_s3_valid || i_out_ready;
        w_s2_en    = !r_s2_valid || w_s3_en;
        w_s1_en    = !r_s1_valid || w_s2_en;
        o_in_ready = w_s1_en && i_rst_n;
    end

    // Chain of 3:2 compressors folding all rows into sum/carry.
    always_comb begin
        w_csa_sum   = r_s1_rows[0];
        w_csa_carry = r_s1_rows[1];
        w_csa_tmp   = '0;
        for (int unsigned k = 2; k < ROWS; k++) begin
            w_csa_tmp   = w_csa_sum ^ w_csa_carry ^ r_s1_rows[k];
            w_csa_carry = ((w_csa_sum & w_csa_carry) | (w_csa_sum & r_s1_rows[k]) |
                           (w_csa_carry & r_s1_rows[k])) << 1;
            w_csa_sum   = w_csa_tmp;
        end
    end

    // Valid flags and output registers; reset discards everything in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s3_prod  <= '0;
            r_s3_tag   <= '0;
        end else begin
            if (w_s1_en) r_s1_valid <= i_in_valid;
            if (w_s2_en) r_s2_valid <= r_s1_valid;
            if (w_s3_en) begin
                r_s3_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_s3_prod <= r_s2_sum + r_s2_carry;
                    r_s3_tag  <= r_s2_tag;
                end
            end
        end
    end

    // Internal data registers only load alongside a valid beat; no reset needed.
    always_ff @(posedge i_clk) begin
        if (w_s1_en && i_in_valid) begin
            r_s1_rows <= w_rows;
            r_s1_tag  <= i_in_tag;
        end
        if (w_s2_en && r_s1_valid) begin
            r_s2_sum   <= w_csa_sum;
            r_s2_carry <= w_csa_carry;
            r_s2_tag   <= r_s1_tag;
        end
    end

    assign o_out_valid = r_s3_valid;
    assign o_out_prod  = r_s3_prod;
    assign o_out_tag   = r_s3_tag;

endmodule
